instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ERRCNT_W, default 8, width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request carries fields to encode.
REQ-005 in_ready  output  1  encoder accepts the request this cycle.
REQ-006 immsrc  input  2  format select: 00 I, 01 S, 10 B, 11 J; same coding as the immediate extender.
REQ-007 imm  input  32  signed byte-offset immediate to pack.
REQ-008 opcode  input  7  passed to instr[6:0].
REQ-009 rd, rs1, rs2  input  5 each  register fields.
REQ-010 funct3  input  3  passed to instr[14:12] for I/S/B.
REQ-011 out_valid  output  1  instr/err hold a valid encoded word.
REQ-012 out_ready  input  1  downstream consumes the word.
REQ-013 instr  output  32  encoded instruction word.
REQ-014 err  output  1  immediate out of range or misaligned for the selected format.
REQ-015 err_clr  input  1  clears err_cnt.
REQ-016 err_cnt  output  ERRCNT_W  number of accepted requests flagged err, saturating.

Function
REQ-017 Packing, I: instr = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-018 Packing, S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-019 Packing, B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-020 Packing, J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-021 Round trip: for every in-range imm, sign-extending the produced word with the same immsrc returns imm exactly.
REQ-022 Range: I/S require imm[31:11] all equal; B requires imm[31:12] all equal and imm[0]=0; J requires imm[31:20] all equal and imm[0]=0; violation sets err.
REQ-023 On err, instr still carries the truncated packing per REQ-017..020; no substitution.
REQ-024 One output register stage; latency one cycle from accept to out_valid.
REQ-025 in_ready = !out_valid || out_ready (combinational); full throughput of one word per cycle.
REQ-026 Accept = in_valid && in_ready; on accept, instr/err load and out_valid sets next cycle.
REQ-027 out_valid && !out_ready: instr, err, out_valid hold stable; no input accepted.
REQ-028 Output taken with no accept: out_valid clears; instr/err hold last value.
REQ-029 Simultaneous take and accept: new word loads, out_valid stays 1.
REQ-030 err_cnt increments on each accept with err true, saturating at all-ones.
REQ-031 err_clr and a counted error in the same cycle: err_clr wins, err_cnt = 0.

Reset
REQ-032 Reset: out_valid=0, instr=32'h0, err=0, err_cnt=0; in_ready=1 the cycle after.
REQ-033 Reset mid-transfer discards any held word; no word is replayed.

Configuration
REQ-034 Macro INSTR_ENC_RANGE_CHECK_EN defined: REQ-022, REQ-030, REQ-031 active.
REQ-035 Macro undefined: err tied 0, err_cnt tied 0, err_clr ignored, no range logic or counter flops; packing and handshake unchanged.

Structure
REQ-036 Shared package instr_enc_pkg holds the immsrc enum (IMM_I, IMM_S, IMM_B, IMM_J) and opcode constants; the immediate extender uses the same enum.
REQ-037 Combinational sub-module imm_pack (immsrc, imm, register fields -> word, err) feeds the output register.

Verification
REQ-038 I, imm=-1 (32'hFFFFFFFF), rs1=2, rd=1, funct3=0, opcode=7'h13 -> instr=32'hFFF10093, err=0, one cycle later.
REQ-039 B, imm=32'h00000FFE, rs1=1, rs2=2, funct3=0, opcode=7'h63 -> instr=32'h7E208FE3, err=0; imm=32'h00001001 -> err=1, err_cnt+1.
REQ-040 J, imm=32'h00100000, rd=0, opcode=7'h6F -> err=1; imm=32'hFFF00000 -> instr=32'h8000006F, err=0.
REQ-041 out_ready low 5 cycles with in_valid high -> in_ready=0, instr stable; out_ready high -> one word per cycle, none lost or duplicated.
REQ-042 Random in-range imm for all four formats, 10k words -> extender(instr, immsrc)==imm every word.
REQ-043 ERRCNT_W=2, 5 error words -> err_cnt=3; err_clr with concurrent error -> err_cnt=0; reset asserted with out_valid=1 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types for the instruction encoder and the immediate extender:
// immediate format select, common opcodes and the sign-extending decoder.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    // Decode side of the packing: recovers the signed byte offset from a word.
    function automatic logic [31:0] imm_extend(input logic [31:0] word, input immsrc_e fmt);
        logic [31:0] ext;
        case (fmt)
            IMM_I:   ext = {{20{word[31]}}, word[31:20]};
            IMM_S:   ext = {{20{word[31]}}, word[31:25], word[11:7]};
            IMM_B:   ext = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
            IMM_J:   ext = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
            default: ext = 32'h0000_0000;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: places the immediate and register fields for the
// selected format and, with INSTR_ENC_RANGE_CHECK_EN, flags unencodable immediates.
module imm_pack (
    input  logic [1:0]  immsrc,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    output logic [31:0] word,
    output logic        err
);
    import instr_enc_pkg::*;

    immsrc_e fmt_s;
    assign fmt_s = immsrc_e'(immsrc);

    // Bit placement per format; out-of-range values are simply truncated.
    always_comb begin
        word = 32'h0000_0000;
        case (fmt_s)
            IMM_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            IMM_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            IMM_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = {imm[11:0], rs1, funct3, rd, opcode};
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // An immediate fits when every bit above the field's sign bit copies it.
    always_comb begin
        err = 1'b0;
        case (fmt_s)
            IMM_I, IMM_S: err = !((&imm[31:11]) || !(|imm[31:11]));
            IMM_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            IMM_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default:      err = 1'b0;
        endcase
    end
`else
    logic unused_imm_s;
    assign unused_imm_s = ^imm[31:21];
    assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder with a single valid/ready output register stage.
// Optional range checking and error counting: INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          immsrc,
    input  logic [31:0]         imm,
    input  logic [6:0]          opcode,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [2:0]          funct3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         instr,
    output logic                err,
    input  logic                err_clr,
    output logic [ERRCNT_W-1:0] err_cnt
);
    import instr_enc_pkg::*;

    logic [31:0] pack_word_s;
    logic        pack_err_s;
    logic        accept_s;
    logic        out_valid_r;
    logic [31:0] instr_r;
    logic        err_r;

    imm_pack u_imm_pack (
        .immsrc (immsrc),
        .imm    (imm),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .word   (pack_word_s),
        .err    (pack_err_s)
    );

    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign instr     = instr_r;
    assign err       = err_r;

    // Output stage: load on accept, drop valid when taken, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            instr_r     <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            instr_r     <= pack_word_s;
            err_r       <= pack_err_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic [ERRCNT_W-1:0] err_cnt_r;

    // Saturating count of accepted flagged words; a clear beats a new error.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= {ERRCNT_W{1'b0}};
        end else if (err_clr) begin
            err_cnt_r <= {ERRCNT_W{1'b0}};
        end else if (accept_s && pack_err_s && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign err_cnt = {ERRCNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a behavioural model built from the
// format rules and signed ranges, a per-cycle compare, and directed literals.
module tb_instr_encoder;

    localparam int CW = 2;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, out_ready, err_clr;
    logic [1:0]  immsrc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    wire         in_ready, out_valid, err;
    wire [31:0]  instr;
    wire [CW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.ERRCNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1),
        .rs2(rs2), .funct3(funct3), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .err(err), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word straight from the field layout of each format.
    function automatic logic [31:0] pack_ref(input logic [1:0] s, input logic [31:0] v,
                                             input logic [6:0] op, input logic [4:0] d,
                                             input logic [4:0] a, input logic [4:0] b,
                                             input logic [2:0] f);
        logic [31:0] w;
        w = 32'h0;
        w[6:0] = op;
        case (s)
            2'd0: begin w[31:20] = v[11:0]; w[19:15] = a; w[14:12] = f; w[11:7] = d; end
            2'd1: begin w[31:25] = v[11:5]; w[24:20] = b; w[19:15] = a; w[14:12] = f; w[11:7] = v[4:0]; end
            2'd2: begin w[31] = v[12]; w[30:25] = v[10:5]; w[24:20] = b; w[19:15] = a;
                        w[14:12] = f; w[11:8] = v[4:1]; w[7] = v[11]; end
            default: begin w[31] = v[20]; w[30:21] = v[10:1]; w[20] = v[11];
                           w[19:12] = v[19:12]; w[11:7] = d; end
        endcase
        return w;
    endfunction

    // Encodable offsets expressed as signed intervals plus alignment.
    function automatic bit in_range(input logic [1:0] s, input logic [31:0] v);
        int x;
        x = v;
        case (s)
            2'd0, 2'd1: return (x >= -2048) && (x <= 2047);
            2'd2:       return (x >= -4096) && (x <= 4094) && (v[0] == 1'b0);
            default:    return (x >= -1048576) && (x <= 1048574) && (v[0] == 1'b0);
        endcase
    endfunction

    // Reference immediate extender: scatter the word's bits back to an offset.
    function automatic logic [31:0] ext_ref(input logic [31:0] w, input logic [1:0] s);
        int x;
        case (s)
            2'd0: x = $signed(w) >>> 20;
            2'd1: x = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
            2'd2: x = (($signed(w) >>> 31) * 4096) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                      + int'(w[11:8]) * 2;
            default: x = (($signed(w) >>> 31) * 1048576) + int'(w[19:12]) * 4096
                         + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        endcase
        return x;
    endfunction

    typedef struct {
        logic [31:0] v;
        logic [1:0]  s;
        bit          ok;
    } ent_t;

    ent_t        q[$];
    bit          ev = 1'b0;
    logic [31:0] ei = 32'h0;
    bit          ee = 1'b0;
    int          ec = 0;
    int          n_acc = 0;
    int          n_take = 0;
    wire         m_acc = in_valid && (!ev || out_ready);

    // Reference model, advanced on each rising edge from the bench's own inputs.
    always @(posedge clk) begin
        if (reset) begin
            ev <= 1'b0; ei <= 32'h0; ee <= 1'b0; ec <= 0;
            q.delete();
        end else begin
            if (ev && out_ready) begin
                void'(q.pop_front());
                n_take <= n_take + 1;
            end
            if (m_acc) begin
                ev <= 1'b1;
                ei <= pack_ref(immsrc, imm, opcode, rd, rs1, rs2, funct3);
                ee <= RC && !in_range(immsrc, imm);
                q.push_back('{v: imm, s: immsrc, ok: in_range(immsrc, imm)});
                n_acc <= n_acc + 1;
            end else if (out_ready) begin
                ev <= 1'b0;
            end
            if (RC) begin
                if (err_clr) ec <= 0;
                else if (m_acc && !in_range(immsrc, imm) && ec < 3) ec <= ec + 1;
            end
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        chk("out_valid", {31'h0, out_valid}, {31'h0, ev});
        chk("in_ready", {31'h0, in_ready}, {31'h0, (!ev || out_ready)});
        chk("instr", instr, ei);
        chk("err", {31'h0, err}, {31'h0, ee});
        chk("err_cnt", 32'(err_cnt), ec);
        if (ev && q.size() > 0 && q[0].ok)
            chk("roundtrip", ext_ref(instr, q[0].s), q[0].v);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [1:0] s, input logic [31:0] v, input logic [6:0] op,
                            input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                            input logic [2:0] f);
        immsrc = s; imm = v; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f;
    endtask

    task automatic set_rand(input bit allow_bad);
        logic [1:0]  s;
        logic [31:0] v;
        s = 2'($urandom_range(0, 3));
        case (s)
            2'd0, 2'd1: v = $urandom_range(0, 4095) - 2048;
            2'd2:       v = ($urandom_range(0, 4095) - 2048) * 2;
            default:    v = ($urandom_range(0, 1048575) - 524288) * 2;
        endcase
        if (allow_bad && $urandom_range(0, 9) == 0) v = $urandom;
        set_word(s, v, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
    endtask

    logic [31:0] held;
    int          cyc;
    int          start_acc;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        set_word(2'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0);
        step(); step();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        reset = 1'b0;
        step();
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        set_word(2'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("lit_I_instr", instr, 32'hFFF1_0093);
        chk("lit_I_err", {31'h0, err}, 32'h0);
        chk("lit_I_valid", {31'h0, out_valid}, 32'h1);

        set_word(2'd2, 32'h0000_0FFE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0);
        in_valid = 1'b1; step();
        chk("lit_B_instr", instr, 32'h7E20_8FE3);
        chk("lit_B_err", {31'h0, err}, 32'h0);
        set_word(2'd2, 32'h0000_1001, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0);
        step();
        chk("lit_Bbad_err", {31'h0, err}, {31'h0, RC});
        chk("lit_Bbad_cnt", 32'(err_cnt), RC ? 32'd1 : 32'd0);
        set_word(2'd3, 32'h0010_0000, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0);
        step();
        chk("lit_Jbad_err", {31'h0, err}, {31'h0, RC});
        chk("lit_Jbad_instr", instr, 32'h8000_006F);
        set_word(2'd3, 32'hFFF0_0000, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0);
        step(); in_valid = 1'b0;
        chk("lit_J_instr", instr, 32'h8000_006F);
        chk("lit_J_err", {31'h0, err}, 32'h0);
        step();

        out_ready = 1'b0; set_rand(1'b0); in_valid = 1'b1;
        step();
        held = instr;
        for (int i = 0; i < 5; i++) begin
            set_rand(1'b0);
            step();
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_instr_hold", instr, held);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_rand(1'b0);
            step();
        end
        in_valid = 1'b0;
        step();

        start_acc = n_acc;
        cyc = 0;
        while (n_acc < start_acc + 10000 && cyc < 30000) begin
            in_valid = ($urandom_range(0, 15) != 0);
            out_ready = ($urandom_range(0, 7) != 0);
            err_clr = ($urandom_range(0, 49) == 0);
            set_rand(1'b1);
            step();
            cyc++;
        end
        checks++;
        if (n_acc < start_acc + 10000) begin
            errors++;
            $display("FAIL random_budget actual=%0d expected=%0d", n_acc - start_acc, 10000);
        end
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        step(); step();
        chk("no_loss_dup", n_take, n_acc);

        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("cnt_cleared", 32'(err_cnt), 32'h0);
        set_word(2'd2, 32'h0000_1001, 7'h63, 5'd3, 5'd4, 5'd5, 3'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("cnt_saturate", 32'(err_cnt), RC ? 32'd3 : 32'd0);
        err_clr = 1'b1; step(); err_clr = 1'b0; in_valid = 1'b0;
        chk("cnt_clr_wins", 32'(err_cnt), 32'h0);
        step();

        out_ready = 1'b0; set_rand(1'b0); in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_drop_valid", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b1;
        step(); step();
        chk("no_replay", {31'h0, out_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
